mdu_iter: RTL and testbench

//   Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU, the multi-cycle partner of the execute-stage ALU.

---
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_iter.sv | 167 ++++++++++++++++
 tb/tb_mdu_iter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Execute-stage <-> multiply/divide unit port bundle.
//
// Handshake: the execute stage raises start with op/a/b valid for one cycle.
// The unit accepts it only while busy is low and flush is low; once accepted,
// busy stays high until the operation completes or is flushed. Completion is
// a single-cycle done pulse, and hi/lo carry the new result in that same cycle
// and hold it until the next completion.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply and
// restoring divide over operand magnitudes, one bit per cycle, with sign
// correction applied on the final iteration as hi/lo are written.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_if.slave       bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder takes the dividend's (negative) sign
    logic               b_zero;
    logic [WIDTH-1:0]   orig_a;
    logic [WIDTH-1:0]   mag_b;
    // Working register: upper half is the partial product / partial remainder,
    // lower half starts as |a| and is consumed one bit per cycle. For multiply
    // |a| acts as the multiplier (product is commutative); for divide it is the
    // dividend, and quotient bits shift in from the bottom.
    logic [2*WIDTH-1:0] acc;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Operand capture signals, derived from the request inputs
    logic               start_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   start_mag_a;
    logic [WIDTH-1:0]   start_mag_b;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign state_dbg = state;

    // Magnitudes and sign flags of the incoming request (op[0]=0 means signed)
    always_comb begin
        start_signed = ~bus.op[0];
        a_neg        = start_signed & bus.a[WIDTH-1];
        b_neg        = start_signed & bus.b[WIDTH-1];
        start_mag_a  = a_neg ? (~bus.a + ONE_W) : bus.a;
        start_mag_b  = b_neg ? (~bus.b + ONE_W) : bus.b;
    end

    // One multiply or divide step, plus the sign-corrected final result
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        // Shifted partial remainder minus divisor; the top bit acts as the
        // borrow because the shifted remainder is always below 2*divisor.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
        step_next = '0;
        if (is_div) begin
            if (div_trial[WIDTH]) begin
                step_next = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
            end else begin
                step_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_next = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix = neg_res ? (~step_next + ONE_2W) : step_next;
        quot     = step_next[WIDTH-1:0];
        rem      = step_next[2*WIDTH-1:WIDTH];
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                fin_lo = '1;
                fin_hi = orig_a;
            end else begin
                fin_lo = neg_res ? (~quot + ONE_W) : quot;
                fin_hi = neg_rem ? (~rem + ONE_W) : rem;
            end
        end
    end

    // Control FSM with registered busy/done and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            orig_a  <= '0;
            mag_b   <= '0;
            acc     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        state   <= S_RUN;
                        busy_r  <= 1'b1;
                        cnt     <= '0;
                        is_div  <= bus.op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        b_zero  <= (bus.b == '0);
                        orig_a  <= bus.a;
                        mag_b   <= start_mag_b;
                        acc     <= {{WIDTH{1'b0}}, start_mag_a};
                    end else begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else if (cnt == LAST) begin
                        state  <= S_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        acc    <= step_next;
                        hi_r   <= fin_hi;
                        lo_r   <= fin_lo;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed + randomized bench for mdu_iter against a plain-arithmetic model.
module tb_mdu_iter;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference: {hi, lo} from the architectural definition of each op
    function automatic logic [2*W-1:0] model(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint         sa;
        longint         sb;
        longint         sq;
        longint         sr;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        logic [2*W-1:0] t;
        logic [2*W-1:0] tq;
        logic [2*W-1:0] tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 2'b00) begin
            t = sa * sb;
        end else if (op == 2'b01) begin
            t = ua * ub;
        end else if (b == '0) begin
            t = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            tq = sq;
            tr = sr;
            t  = {tr[W-1:0], tq[W-1:0]};
        end else begin
            tq = ua / ub;
            tr = ua % ub;
            t  = {tr[W-1:0], tq[W-1:0]};
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Driver: called at a negedge; presents a request for one cycle and returns
    // at the negedge right after the sampling edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Scoreboard: latency from the post-issue negedge is 32 cycles in total;
    // 'spent' is how many of them the caller already consumed.
    task automatic finish_op(input string tag, input int spent);
        int             n;
        logic [2*W-1:0] expv;
        wait_done(n);
        check({tag, " latency"}, 64'(n + spent), 64'(32));
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " hi_lo"}, {bus.hi, bus.lo}, expv);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
        last_res = expv;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw = 1'b1;
        end
        check({tag, " no_done"}, 64'(saw), 64'(0));
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        last_res  = '0;
        #1;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset hi_lo", {bus.hi, bus.lo}, '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed operations
        issue(2'b00, 32'hFFFF_FFFE, 32'd3);
        check("mult busy", 64'(bus.busy), 64'(1));
        finish_op("mult_m2x3", 0);
        check("mult_m2x3 fixed", last_res, 64'hFFFF_FFFF_FFFF_FFFA);
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFE, 32'd3);
        finish_op("multu_m2x3", 0);
        check("multu_m2x3 fixed", last_res, 64'h0000_0002_FFFF_FFFA);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7_2", 0);
        check("div_m7_2 fixed", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b11, 32'd7, 32'd2);
        finish_op("divu_7_2", 0);
        issue(2'b11, 32'h0000_1234, 32'd0);
        finish_op("divu_by0", 0);
        check("divu_by0 fixed", last_res, 64'h0000_1234_FFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        finish_op("div_by0_neg", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min_m1", 0);
        check("div_min_m1 fixed", last_res, 64'h0000_0000_8000_0000);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        finish_op("mult_min_min", 0);
        check("mult_min_min fixed", last_res, 64'h4000_0000_0000_0000);
        issue(2'b10, 32'd100, 32'hFFFF_FFF9);
        finish_op("div_100_m7", 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            issue(rop, ra, rb);
            finish_op("random", 0);
        end

        // Flush at cycle 10 of RUN: no done, result registers untouched
        @(negedge clk);
        issue(2'b01, 32'h1357_9BDF, 32'h2468_ACE0);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'(0));
        watch_no_done("flush", 40);
        check("flush hold", {bus.hi, bus.lo}, last_res);

        // start together with flush is ignored
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush busy", 64'(bus.busy), 64'(0));
        watch_no_done("start_flush", 40);
        check("start_flush hold", {bus.hi, bus.lo}, last_res);

        // Back-to-back: second start in the done cycle
        issue(2'b00, 32'hFFFF_FF00, 32'h0000_1001);
        finish_op("b2b_first", 0);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_0101);
        check("b2b busy", 64'(bus.busy), 64'(1));
        finish_op("b2b_second", 0);

        // start pulsed while busy is ignored
        @(negedge clk);
        issue(2'b10, 32'h7654_3210, 32'hFFFF_FF85);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("start_while_busy", 5);
        watch_no_done("start_while_busy", 40);

        // Reset mid-RUN clears outputs immediately and yields no done afterwards
        issue(2'b01, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrun_reset busy", 64'(bus.busy), 64'(0));
        check("midrun_reset done", 64'(bus.done), 64'(0));
        check("midrun_reset hi_lo", {bus.hi, bus.lo}, '0);
        @(negedge clk);
        resetn = 1'b1;
        watch_no_done("midrun_reset", 40);
        check("midrun_reset hold", {bus.hi, bus.lo}, '0);

        // Unit still works after reset
        issue(2'b00, 32'h0001_0000, 32'hFFFF_0000);
        finish_op("post_reset", 0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
